// File: rtl/lrwait_tcdm_queue.sv
// lrwait_tcdm_queue: bank-side LRWait/SCWait queue controller in front of one TCDM SRAM bank
// Ports: in_* is the request from the interconnect (in_lrwait_i marks a WakeUp carrying {ini,id}
// in in_data_i), out_* is the registered response (out_lrwait_o marks a SuccUpdate to the old tail),
// mem_* drives a single-port SRAM whose read data returns one cycle after mem_req_o.
module lrwait_tcdm_queue #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int IniWidth  = 8,
  parameter int IdWidth   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [AddrWidth-1:0] in_addr_i,
  input  logic                 in_write_i,
  input  logic [3:0]           in_amo_i,
  input  logic [DataWidth-1:0] in_data_i,
  input  logic [3:0]           in_be_i,
  input  logic [IniWidth-1:0]  in_ini_i,
  input  logic [IdWidth-1:0]   in_id_i,
  input  logic                 in_lrwait_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic [IniWidth-1:0]  out_ini_o,
  output logic [IdWidth-1:0]   out_id_o,
  output logic                 out_lrwait_o,
  output logic                 out_error_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [3:0]           mem_be_o,
  input  logic [DataWidth-1:0] mem_rdata_i
);
  localparam logic [3:0] AmoLr = 4'hC;
  localparam logic [3:0] AmoSc = 4'hD;
  localparam int Pw = IniWidth + IdWidth;
  logic                 busy, released;
  logic [AddrWidth-1:0] resv_addr;
  logic [IniWidth-1:0]  head_ini, tail_ini;
  logic [IdWidth-1:0]   tail_id;
  logic                 out_valid_q, fresh;
  logic [DataWidth-1:0] data_q;
  logic                 accept, is_lr, is_sc, is_plain, same;
  logic                 lr_grant, lr_enq, sc_ok, wake_ok, rd, wr;
  logic [IniWidth-1:0]  pay_ini, resp_ini;
  logic [IdWidth-1:0]   pay_id, resp_id;
  logic [DataWidth-1:0] resp_data;
  logic                 resp_err;
  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign {pay_ini, pay_id} = in_data_i[Pw-1:0];
  assign is_lr    = !in_lrwait_i && in_amo_i == AmoLr;
  assign is_sc    = !in_lrwait_i && in_amo_i == AmoSc;
  assign is_plain = !in_lrwait_i && !is_lr && !is_sc;
  assign same     = busy && in_addr_i == resv_addr;
  assign lr_grant = is_lr && !busy;
  assign lr_enq   = is_lr && same;
  assign sc_ok    = is_sc && same && in_ini_i == head_ini && !released;
  // a WakeUp is only legal from the releasing head while the lock is in handover
  assign wake_ok  = in_lrwait_i && in_amo_i == AmoLr && same && released && in_ini_i == head_ini;
  assign rd = accept && ((is_plain && !in_write_i) || lr_grant || wake_ok);
  assign wr = accept && ((is_plain && in_write_i) || sc_ok);
  assign mem_req_o   = rd || wr;
  assign mem_we_o    = wr;
  assign mem_addr_o  = mem_req_o ? in_addr_i : '0;
  assign mem_wdata_o = wr ? in_data_i : '0;
  assign mem_be_o    = mem_req_o ? in_be_i : '0;
  assign resp_ini  = wake_ok ? pay_ini : lr_enq ? tail_ini : in_ini_i;
  assign resp_id   = wake_ok ? pay_id : lr_enq ? tail_id : in_id_i;
  assign resp_data = lr_enq ? DataWidth'({in_ini_i, in_id_i}) : (is_sc && !sc_ok) ? DataWidth'(1) : '0;
  assign resp_err  = (is_lr && busy && !same) || (is_sc && !sc_ok) || (in_lrwait_i && !wake_ok);
  assign out_valid_o = out_valid_q;
  // read data is passed straight through in the cycle it arrives, then captured so a stall holds it
  assign out_data_o  = fresh ? mem_rdata_i : data_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      fresh        <= 1'b0;
      data_q       <= '0;
      out_ini_o    <= '0;
      out_id_o     <= '0;
      out_lrwait_o <= 1'b0;
      out_error_o  <= 1'b0;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      fresh        <= rd;
      data_q       <= resp_data;
      out_ini_o    <= resp_ini;
      out_id_o     <= resp_id;
      out_lrwait_o <= lr_enq;
      out_error_o  <= resp_err;
    end else begin
      if (out_ready_i) out_valid_q <= 1'b0;
      if (fresh) begin
        data_q <= mem_rdata_i;
        fresh  <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy      <= 1'b0;
      released  <= 1'b0;
      resv_addr <= '0;
      head_ini  <= '0;
      tail_ini  <= '0;
      tail_id   <= '0;
    end else if (accept) begin
      if (lr_grant) begin
        busy      <= 1'b1;
        released  <= 1'b0;
        resv_addr <= in_addr_i;
        head_ini  <= in_ini_i;
        tail_ini  <= in_ini_i;
        tail_id   <= in_id_i;
      end
      if (lr_enq) begin
        tail_ini <= in_ini_i;
        tail_id  <= in_id_i;
      end
      // the head releasing with nobody behind it empties the queue
      if (sc_ok) begin
        if (tail_ini == head_ini) busy <= 1'b0;
        else released <= 1'b1;
      end
      if (wake_ok) begin
        head_ini <= pay_ini;
        released <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lrwait_tcdm_queue.sv
// tb_lrwait_tcdm_queue: directed and randomized checks of lrwait_tcdm_queue against a request-level model
module tb_lrwait_tcdm_queue;
  localparam int GRANT = 1, ENQ = 2, SCOK = 3, WAKE = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid, in_ready_o, in_write, in_lrwait, out_ready;
  logic [31:0] in_addr, in_data;
  logic [3:0] in_amo, in_be;
  logic [7:0] in_ini, in_id;
  logic out_valid_o, out_lrwait_o, out_error_o;
  logic [31:0] out_data_o;
  logic [7:0] out_ini_o, out_id_o;
  logic mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, rdata;
  logic [3:0] mem_be_o;
  logic [31:0] bank [0:1023];
  logic bank_init = 1'b0;
  logic [31:0] ref_mem [0:1023];
  logic [31:0] addrs [3];
  logic m_valid, m_busy, m_rel, m_lrw, m_err;
  logic [31:0] m_resv, m_data;
  logic [7:0] m_head, m_tail_ini, m_tail_id, m_ini, m_id;
  logic exp_ready, exp_req, exp_we, acc, nr_lrw, nr_err;
  logic [31:0] exp_addr, nr_data;
  logic [7:0] nr_ini, nr_id;
  int ev;
  logic cmp_on = 1'b0;
  int total = 0;
  int passed = 0;

  lrwait_tcdm_queue dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o), .in_addr_i(in_addr), .in_write_i(in_write),
    .in_amo_i(in_amo), .in_data_i(in_data), .in_be_i(in_be), .in_ini_i(in_ini), .in_id_i(in_id),
    .in_lrwait_i(in_lrwait),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready), .out_data_o(out_data_o), .out_ini_o(out_ini_o),
    .out_id_o(out_id_o), .out_lrwait_o(out_lrwait_o), .out_error_o(out_error_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o), .mem_rdata_i(rdata)
  );

  always #5 clk = ~clk;

  // SRAM bank seen by the DUT
  always @(posedge clk) begin
    if (!bank_init) begin
      for (int i = 0; i < 1024; i++) bank[i] <= 32'hA000_0000 | i;
      bank_init <= 1'b1;
    end else if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) bank[mem_addr_o[11:2]][8*b+:8] <= mem_wdata_o[8*b+:8];
      end else rdata <= bank[mem_addr_o[11:2]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // expected response and SRAM access for the request currently on the inputs
  task automatic predict();
    logic same;
    exp_ready = !m_valid || out_ready;
    acc = in_valid && exp_ready;
    same = m_busy && in_addr == m_resv;
    nr_ini = in_ini; nr_id = in_id; nr_data = 0; nr_lrw = 0; nr_err = 0;
    exp_req = 0; exp_we = 0; exp_addr = in_addr; ev = 0;
    if (in_lrwait) begin
      if (in_amo == 4'hC && same && m_rel && in_ini == m_head) begin
        ev = WAKE; exp_req = 1; exp_addr = m_resv;
        nr_ini = in_data[15:8]; nr_id = in_data[7:0]; nr_data = ref_mem[m_resv[11:2]];
      end else nr_err = 1;
    end else if (in_amo == 4'hC) begin
      if (!m_busy) begin
        ev = GRANT; exp_req = 1; nr_data = ref_mem[in_addr[11:2]];
      end else if (same) begin
        ev = ENQ; nr_ini = m_tail_ini; nr_id = m_tail_id; nr_lrw = 1; nr_data = {16'h0, in_ini, in_id};
      end else nr_err = 1;
    end else if (in_amo == 4'hD) begin
      if (same && in_ini == m_head && !m_rel) begin
        ev = SCOK; exp_req = 1; exp_we = 1;
      end else begin
        nr_data = 1; nr_err = 1;
      end
    end else begin
      exp_req = 1; exp_we = in_write;
      if (!in_write) nr_data = ref_mem[in_addr[11:2]];
    end
    if (!acc) begin
      exp_req = 0; exp_we = 0; ev = 0;
    end
  endtask

  task automatic commit();
    @(posedge clk);
    if (m_valid && out_ready) m_valid = 0;
    if (acc) begin
      m_valid = 1; m_data = nr_data; m_ini = nr_ini; m_id = nr_id; m_lrw = nr_lrw; m_err = nr_err;
      if (exp_we)
        for (int b = 0; b < 4; b++)
          if (in_be[b]) ref_mem[exp_addr[11:2]][8*b+:8] = in_data[8*b+:8];
      case (ev)
        GRANT: begin
          m_busy = 1; m_rel = 0; m_resv = in_addr; m_head = in_ini; m_tail_ini = in_ini; m_tail_id = in_id;
        end
        ENQ: begin
          m_tail_ini = in_ini; m_tail_id = in_id;
        end
        SCOK: if (m_tail_ini == m_head) m_busy = 0; else m_rel = 1;
        WAKE: begin
          m_head = in_data[15:8]; m_rel = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic w, input logic [3:0] amo,
                       input logic [31:0] d, input logic [3:0] be, input logic [7:0] ini,
                       input logic [7:0] id, input logic lrw, input logic ordy);
    @(negedge clk);
    in_valid = v; in_addr = a; in_write = w; in_amo = amo; in_data = d; in_be = be;
    in_ini = ini; in_id = id; in_lrwait = lrw; out_ready = ordy;
    predict();
  endtask

  task automatic req(input logic [31:0] a, input logic [3:0] amo, input logic [7:0] ini,
                     input logic [7:0] id, input logic [31:0] d, input logic lrw, input logic w);
    drive(1, a, w, amo, d, 4'hF, ini, id, lrw, 1);
    commit();
  endtask

  task automatic idle(input logic ordy);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, ordy);
  endtask

  task automatic resp(input string n, input logic [7:0] ini, input logic [7:0] id,
                      input logic [31:0] d, input logic lrw, input logic err);
    idle(1);
    #3;
    chk({n, "_ini"}, 32'(out_ini_o), 32'(ini));
    chk({n, "_id"}, 32'(out_id_o), 32'(id));
    chk({n, "_data"}, out_data_o, d);
    chk({n, "_lrwait"}, 32'(out_lrwait_o), 32'(lrw));
    chk({n, "_error"}, 32'(out_error_o), 32'(err));
    commit();
  endtask

  task automatic rand_cycle();
    logic [31:0] a, d;
    logic [7:0] ini, id;
    logic [3:0] amo, be;
    logic v, w, lrw, ordy;
    int op;
    op = $urandom_range(0, 9);
    v = $urandom_range(0, 9) < 8;
    ordy = $urandom_range(0, 9) < 7;
    ini = 8'($urandom_range(1, 4));
    id = 8'($urandom);
    d = $urandom;
    be = 4'($urandom_range(1, 15));
    w = 0; lrw = 0; amo = 0;
    a = ($urandom_range(0, 9) < 8) ? 32'h100 : addrs[$urandom_range(1, 2)];
    if (op <= 2) begin
      a = addrs[$urandom_range(0, 2)]; w = 1'($urandom_range(0, 1));
    end else if (op <= 4) amo = 4'hC;
    else if (op <= 6) begin
      amo = 4'hD;
      if ($urandom_range(0, 9) < 7) ini = m_head;
    end else if (op <= 8) begin
      lrw = 1;
      amo = ($urandom_range(0, 9) < 9) ? 4'hC : 4'h0;
      if ($urandom_range(0, 9) < 7) ini = m_head;
      if ($urandom_range(0, 1) == 1) d[15:0] = {m_tail_ini, m_tail_id};
    end else v = 0;
    drive(v, a, w, amo, d, be, ini, id, lrw, ordy);
    commit();
  endtask

  always begin
    @(negedge clk);
    #2;
    if (cmp_on) begin
      chk("in_ready", 32'(in_ready_o), 32'(exp_ready));
      chk("out_valid", 32'(out_valid_o), 32'(m_valid));
      if (m_valid) begin
        chk("out_data", out_data_o, m_data);
        chk("out_ini", 32'(out_ini_o), 32'(m_ini));
        chk("out_id", 32'(out_id_o), 32'(m_id));
        chk("out_lrwait", 32'(out_lrwait_o), 32'(m_lrw));
        chk("out_error", 32'(out_error_o), 32'(m_err));
      end
      chk("mem_req", 32'(mem_req_o), 32'(exp_req));
      if (exp_req) begin
        chk("mem_we", 32'(mem_we_o), 32'(exp_we));
        chk("mem_addr", mem_addr_o, exp_addr);
        if (exp_we) begin
          chk("mem_wdata", mem_wdata_o, in_data);
          chk("mem_be", 32'(mem_be_o), 32'(in_be));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hA000_0000 | i;
    addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h200;
    m_valid = 0; m_busy = 0; m_rel = 0; m_resv = 0; m_head = 0; m_tail_ini = 0; m_tail_id = 0;
    m_data = 0; m_ini = 0; m_id = 0; m_lrw = 0; m_err = 0;
    in_valid = 0; in_addr = 0; in_write = 0; in_amo = 0; in_data = 0; in_be = 0;
    in_ini = 0; in_id = 0; in_lrwait = 0; out_ready = 1;
    predict();
    repeat (3) @(negedge clk);
    rst_n = 1;
    predict();
    cmp_on = 1;
    #3;
    chk("rst_out_valid", 32'(out_valid_o), 32'h0);
    chk("rst_in_ready", 32'(in_ready_o), 32'h1);
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    commit();
    // single core grant and release
    drive(1, 32'h100, 0, 4'hC, 0, 4'hF, 8'd3, 8'd5, 0, 1);
    #3;
    chk("grant_req", 32'(mem_req_o), 32'h1);
    chk("grant_we", 32'(mem_we_o), 32'h0);
    commit();
    resp("grant", 8'd3, 8'd5, 32'hA000_0040, 0, 0);
    req(32'h100, 4'hD, 8'd3, 8'd5, 32'h42, 0, 0);
    resp("sc", 8'd3, 8'd5, 32'h0, 0, 0);
    chk("model_empty1", 32'(m_busy), 32'h0);
    req(32'h100, 4'h0, 8'd3, 8'd5, 0, 0, 0);
    resp("rd42", 8'd3, 8'd5, 32'h42, 0, 0);
    // two cores with handover
    req(32'h100, 4'hC, 8'd3, 8'd5, 0, 0, 0);
    resp("grant2", 8'd3, 8'd5, 32'h42, 0, 0);
    drive(1, 32'h100, 0, 4'hC, 0, 4'hF, 8'd7, 8'd2, 0, 1);
    #3;
    chk("succ_noreq", 32'(mem_req_o), 32'h0);
    commit();
    resp("succ", 8'd3, 8'd5, 32'h0702, 1, 0);
    req(32'h100, 4'hD, 8'd3, 8'd5, 32'h55, 0, 0);
    resp("sc_hand", 8'd3, 8'd5, 32'h0, 0, 0);
    chk("model_handover", 32'(m_rel), 32'h1);
    drive(1, 32'h100, 0, 4'hC, 32'h0702, 4'hF, 8'd3, 8'd5, 1, 1);
    #3;
    chk("wake_req", 32'(mem_req_o), 32'h1);
    chk("wake_addr", mem_addr_o, 32'h100);
    commit();
    resp("wake", 8'd7, 8'd2, 32'h55, 0, 0);
    req(32'h100, 4'hD, 8'd7, 8'd2, 32'h66, 0, 0);
    resp("sc_b", 8'd7, 8'd2, 32'h0, 0, 0);
    chk("model_empty2", 32'(m_busy), 32'h0);
    // three cores
    req(32'h100, 4'hC, 8'd3, 8'd5, 0, 0, 0);
    resp("g3", 8'd3, 8'd5, 32'h66, 0, 0);
    req(32'h100, 4'hC, 8'd7, 8'd2, 0, 0, 0);
    resp("succ_ab", 8'd3, 8'd5, 32'h0702, 1, 0);
    req(32'h100, 4'hC, 8'd9, 8'd1, 0, 0, 0);
    resp("succ_bc", 8'd7, 8'd2, 32'h0901, 1, 0);
    req(32'h100, 4'hD, 8'd3, 8'd5, 32'h11, 0, 0);
    resp("sc3a", 8'd3, 8'd5, 32'h0, 0, 0);
    req(32'h100, 4'hC, 8'd3, 8'd5, 32'h0702, 1, 0);
    resp("wake3b", 8'd7, 8'd2, 32'h11, 0, 0);
    req(32'h100, 4'hD, 8'd7, 8'd2, 32'h22, 0, 0);
    resp("sc3b", 8'd7, 8'd2, 32'h0, 0, 0);
    req(32'h100, 4'hC, 8'd7, 8'd2, 32'h0901, 1, 0);
    resp("wake3c", 8'd9, 8'd1, 32'h22, 0, 0);
    req(32'h100, 4'hD, 8'd9, 8'd1, 32'h33, 0, 0);
    resp("sc3c", 8'd9, 8'd1, 32'h0, 0, 0);
    chk("model_empty3", 32'(m_busy), 32'h0);
    // protocol errors
    req(32'h100, 4'hC, 8'd3, 8'd5, 0, 0, 0);
    resp("g4", 8'd3, 8'd5, 32'h33, 0, 0);
    req(32'h100, 4'hD, 8'd7, 8'd2, 32'h77, 0, 0);
    resp("sc_nonhead", 8'd7, 8'd2, 32'h1, 0, 1);
    req(32'h100, 4'h0, 8'd3, 8'd5, 0, 0, 0);
    resp("mem_unchanged", 8'd3, 8'd5, 32'h33, 0, 0);
    req(32'h200, 4'hC, 8'd7, 8'd2, 0, 0, 0);
    resp("lr_other", 8'd7, 8'd2, 32'h0, 0, 1);
    req(32'h100, 4'hD, 8'd3, 8'd5, 32'h44, 0, 0);
    resp("sc4", 8'd3, 8'd5, 32'h0, 0, 0);
    req(32'h100, 4'hC, 8'd3, 8'd5, 32'h0702, 1, 0);
    resp("wake_empty", 8'd3, 8'd5, 32'h0, 0, 1);
    // response stall
    req(32'h100, 4'hC, 8'd3, 8'd5, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'h100, 0, 4'hC, 0, 4'hF, 8'd7, 8'd2, 0, 0);
      #3;
      chk("stall_ready", 32'(in_ready_o), 32'h0);
      chk("stall_req", 32'(mem_req_o), 32'h0);
      chk("stall_data", out_data_o, 32'h44);
      commit();
    end
    drive(1, 32'h100, 0, 4'hC, 0, 4'hF, 8'd7, 8'd2, 0, 1);
    #3;
    chk("release_ready", 32'(in_ready_o), 32'h1);
    commit();
    resp("stall_succ", 8'd3, 8'd5, 32'h0702, 1, 0);
    // reset while in handover with a response pending
    req(32'h100, 4'hD, 8'd3, 8'd5, 32'h88, 0, 0);
    idle(0);
    commit();
    @(negedge clk);
    rst_n = 0; in_valid = 0; out_ready = 1;
    m_valid = 0; m_busy = 0; m_rel = 0;
    predict();
    #1;
    chk("midrst_valid", 32'(out_valid_o), 32'h0);
    chk("midrst_ready", 32'(in_ready_o), 32'h1);
    commit();
    @(negedge clk);
    rst_n = 1;
    predict();
    commit();
    req(32'h100, 4'hC, 8'd9, 8'd1, 0, 0, 0);
    resp("post_rst", 8'd9, 8'd1, 32'h88, 0, 0);
    repeat (3000) rand_cycle();
    idle(1);
    commit();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
